// File: rtl/systolic_mm_param.sv
// Parametrised NxN output-stationary systolic matrix multiplier, Y = A x B, signed operands.
// Define SYSTOLIC_SAT_EN for saturating accumulation and the sticky sat_flag output.
module systolic_mm_param #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] mat_y,
  output logic              busy
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int FL = 2*N - 1;
  localparam int CW = $clog2(3*N);
  // Runs one cycle past the last skewed product so the PE input registers drain.
  localparam logic [CW-1:0] CNT_LAST = CW'(3*N - 2);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          capture, run;

  logic signed [DW-1:0] a_head [N];
  logic signed [DW-1:0] b_head [N];
  logic signed [DW-1:0] a_pipe [N][N-1];
  logic signed [DW-1:0] b_pipe [N-1][N];
`ifdef SYSTOLIC_SAT_EN
  logic [N*N-1:0] clip;
`endif

  assign capture = (state_q == IDLE) && in_valid;
  assign run     = (state_q == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture)  cnt_q <= '0;
      else if (run) cnt_q <= cnt_q + CW'(1);
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:     if (cnt_q == CNT_LAST) state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row feeder r holds r leading zeros then a[r][*]; column feeder r likewise for b[*][r].
  for (genvar r = 0; r < N; r++) begin : g_feed
    logic signed [DW-1:0] fa_q [FL];
    logic signed [DW-1:0] fb_q [FL];

    // NOTE: the skew arrays are reset explicitly so an aborted operation leaves no stale operands.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int m = 0; m < FL; m++) begin
          fa_q[m] <= '0;
          fb_q[m] <= '0;
        end
      end else if (capture) begin
        for (int m = 0; m < FL; m++) begin
          fa_q[m] <= '0;
          fb_q[m] <= '0;
        end
        for (int k = 0; k < N; k++) begin
          fa_q[r+k] <= mat_a[(r*N+k)*DW +: DW];
          fb_q[r+k] <= mat_b[(k*N+r)*DW +: DW];
        end
      end else if (run) begin
        for (int m = 0; m < FL-1; m++) begin
          fa_q[m] <= fa_q[m+1];
          fb_q[m] <= fb_q[m+1];
        end
        fa_q[FL-1] <= '0;
        fb_q[FL-1] <= '0;
      end
    end

    assign a_head[r] = fa_q[0];
    assign b_head[r] = fb_q[0];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0]   a_in, b_in, a_q, b_q;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   prod_ext, acc_q, acc_d;

      if (j == 0) begin : g_a_edge
        assign a_in = a_head[i];
      end else begin : g_a_int
        assign a_in = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_head[j];
      end else begin : g_b_int
        assign b_in = b_pipe[i-1][j];
      end
      if (j < N-1) begin : g_a_fwd
        assign a_pipe[i][j] = a_q;
      end
      if (i < N-1) begin : g_b_fwd
        assign b_pipe[i][j] = b_q;
      end

      assign prod     = (2*DW)'(a_q) * (2*DW)'(b_q);
      assign prod_ext = AW'(prod);

`ifdef SYSTOLIC_SAT_EN
      logic [AW:0] sum;
      assign sum         = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
      assign clip[i*N+j] = sum[AW] ^ sum[AW-1];
      always_comb begin
        acc_d = sum[AW-1:0];
        if (clip[i*N+j]) acc_d = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
`else
      assign acc_d = acc_q + prod_ext;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (capture) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (run) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= acc_d;
        end
      end

      assign mat_y[(i*N+j)*AW +: AW] = acc_q;
    end
  end

`ifdef SYSTOLIC_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              sat_flag <= 1'b0;
    else if (capture)       sat_flag <= 1'b0;
    else if (run && |clip)  sat_flag <= 1'b1;
  end
`endif

endmodule
